// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: funct3 load/store encodings
// and small helpers for classifying M-stage memory accesses.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic ld_f3_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic st_f3_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // Size is encoded in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic m;
    m = 1'b0;
    unique case (f3[1:0])
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data extraction: picks the byte/half lane selected by
// the low address bits and sign- or zero-extends it.
module load_align
  import riscv_pkg::*;
#(
  parameter int word_width = 32
) (
  input  logic [word_width-1:0] rdata_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_lo_i,
  output logic [word_width-1:0] data_o
);

  logic [word_width-1:0] sh;
  logic [7:0]            b;
  logic [15:0]           h;

  assign sh = rdata_i >> {addr_lo_i, 3'b000};
  assign b  = sh[7:0];
  assign h  = sh[15:0];

  // Format the selected lane according to the load type.
  always_comb begin
    data_o = rdata_i;
    unique case (funct3_i)
      F3_LB:   data_o = {{(word_width-8){b[7]}}, b};
      F3_LH:   data_o = {{(word_width-16){h[15]}}, h};
      F3_LBU:  data_o = {{(word_width-8){1'b0}}, b};
      F3_LHU:  data_o = {{(word_width-16){1'b0}}, h};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data memory access unit: issues one bus request per
// load/store, stalls the pipeline until it completes.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  output logic [word_width-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [word_width-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [word_width-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [word_width-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                  is_ld, is_st;
  logic                  ok, mis, acc, bad;
  logic [3:0]            be_in;
  logic [word_width-1:0] wdata_in;
  logic [word_width-1:0] addr_in;

  logic                  we_q;
  logic [3:0]            be_q;
  logic [word_width-1:0] wdata_q;
  logic [word_width-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [1:0]            lo_q;
  logic [word_width-1:0] res_q;
  logic [word_width-1:0] aligned;

  logic                  req, stall, misal;
  logic                  idle;

  // A load wins when both strobes are set.
  assign is_ld = MemReadM;
  assign is_st = MemWriteM & ~MemReadM;
  assign ok    = (is_ld & ld_f3_ok(Funct3M)) |
                 (is_st & st_f3_ok(Funct3M));
  assign mis   = misaligned(Funct3M, ALUResultM[1:0]);
  assign acc   = ok & ~mis;
  assign bad   = ok & mis;

  assign addr_in = {ALUResultM[word_width-1:2], 2'b00};

  // Byte enables and replicated store data for the M-stage store.
  always_comb begin
    be_in    = 4'b0000;
    wdata_in = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        be_in    = 4'b0001 << ALUResultM[1:0];
        wdata_in = {(word_width/8){WriteDataM[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << ALUResultM[1:0];
        wdata_in = {(word_width/16){WriteDataM[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = WriteDataM;
      end
    endcase
  end

  load_align #(
    .word_width(word_width)
  ) u_align (
    .rdata_i  (dmem_rdata),
    .funct3_i (f3_q),
    .addr_lo_i(lo_q),
    .data_o   (aligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/stall outputs.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    misal   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem_gnt) state_d = is_st ? S_DONE : S_RESP;
          else          state_d = S_REQ;
        end else if (bad) begin
          misal = 1'b1;
        end
      end
      S_REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_gnt) state_d = we_q ? S_DONE : S_RESP;
      end
      S_RESP: begin
        stall = 1'b1;
        if (dmem_rvalid) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Freeze the request fields once it is issued from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      lo_q    <= 2'b00;
    end else if (state_q == S_IDLE && acc) begin
      we_q    <= is_st;
      be_q    <= be_in;
      wdata_q <= wdata_in;
      addr_q  <= addr_in;
      f3_q    <= Funct3M;
      lo_q    <= ALUResultM[1:0];
    end
  end

  // Formatted load result, held until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (state_q == S_RESP && dmem_rvalid) begin
      res_q <= aligned;
    end
  end

  assign idle       = (state_q == S_IDLE);
  assign dmem_req   = req & rst_n;
  assign StallM     = stall & rst_n;
  assign MisalignM  = misal & rst_n;
  assign dmem_we    = idle ? is_st    : we_q;
  assign dmem_addr  = idle ? addr_in  : addr_q;
  assign dmem_be    = idle ? be_in    : be_q;
  assign dmem_wdata = idle ? wdata_in : wdata_q;
  assign ReadDataM  = res_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a behavioural
// model of load/store formatting and stall latency.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_cmp;
  int n_err;
  logic [31:0] last_rd;

  mem_access_unit #(.word_width(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [1:0] lo,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(lo));
    case (f3)
      3'd0: begin v = v & 32'hFF; if (v >= 32'h80) v = v - 32'h100; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = m_size(f3);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  // One M-stage access; called just after a rising edge.
  task automatic access(input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int gd,
                        input int rvd, input logic [31:0] rdat);
    bit ld, st, ok, mis, fin;
    int sz, exp_st, stalls, reqc, respc, phase;
    logic [31:0] exp_be;
    ld  = rd;
    st  = wr && !rd;
    ok  = (ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
          (st && (f3 inside {3'd0, 3'd1, 3'd2}));
    sz  = m_size(f3);
    mis = ok && ((int'(addr[1:0]) % sz) != 0);
    exp_st = (!ok || mis) ? 0 : (ld ? gd + rvd + 2 : gd + 1);
    exp_be = 32'((((1 << sz) - 1) << int'(addr[1:0])) & 15);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    stalls = 0; reqc = 0; respc = 0; phase = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (!StallM) begin
        fin = 1;
        chk("stall_cycles", 32'(stalls), 32'(exp_st));
        chk("misalign", {31'd0, MisalignM}, {31'd0, mis});
        chk("req_end", {31'd0, dmem_req}, 32'd0);
        if (ok && !mis && ld) last_rd = m_load(f3, addr[1:0], rdat);
        chk("rdata", ReadDataM, last_rd);
      end else begin
        stalls++;
        chk("mis_stall", {31'd0, MisalignM}, 32'd0);
        if (phase == 0) begin
          chk("req", {31'd0, dmem_req}, 32'd1);
          chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
          chk("we", {31'd0, dmem_we}, {31'd0, st});
          chk("be", {28'd0, dmem_be}, exp_be);
          if (st) chk("wdata", dmem_wdata, m_wdata(f3, wd));
          dmem_gnt = (reqc == gd);
          dmem_rvalid = 1'($urandom);
          dmem_rdata = $urandom;
          if (reqc == gd) phase = ld ? 1 : 2;
          reqc++;
        end else if (phase == 1) begin
          chk("req_resp", {31'd0, dmem_req}, 32'd0);
          dmem_gnt = 1'($urandom);
          dmem_rvalid = (respc == rvd);
          dmem_rdata = (respc == rvd) ? rdat : $urandom;
          respc++;
        end else begin
          dmem_gnt = 1'b0;
          dmem_rvalid = 1'b0;
        end
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_rd = '0;
    rst_n = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
    ALUResultM = 32'h100; WriteDataM = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mis", {31'd0, MisalignM}, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1, 0, 3'd2, 32'h100, 0, 0, 0, 32'hDEADBEEF);
    access(1, 0, 3'd0, 32'h103, 0, 1, 2, 32'h80FF_FFFF);
    access(1, 0, 3'd4, 32'h103, 0, 0, 0, 32'h80FF_FFFF);
    access(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 3, 0, 0);
    access(1, 0, 3'd2, 32'h101, 0, 0, 0, 32'h0);
    access(0, 1, 3'd0, 32'h301, 32'h000000A5, 0, 0, 0);
    access(1, 1, 3'd5, 32'h402, 0, 0, 1, 32'h8765_4321);
    access(1, 0, 3'd3, 32'h400, 0, 0, 0, 32'h0);

    // Reset in the middle of a load response wait.
    MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h300;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("resp_stall", {31'd0, StallM}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, StallM}, 32'd0);
    chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_rdata", ReadDataM, 32'd0);
    last_rd = '0;
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rv_rdata", ReadDataM, 32'd0);
    chk("late_rv_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      access(1'($urandom), 1'($urandom), 3'($urandom),
             $urandom, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
